// File: rtl/crypto_pkg.sv
// Shared definitions for the mock crypto path: block width and decrypt FSM states.
package crypto_pkg;

  localparam int DATA_W = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND,
    FINAL,
    OUT
  } dec_state_e;

endpackage

// File: rtl/crypto_decrypt_block.sv
// Mock block decryptor: plaintext = (ciphertext - NUM_ROUNDS) ^ key.
// One block in flight; key material is cleared after every block and on zeroize.
module crypto_decrypt_block #(
  parameter int NUM_ROUNDS = 1,
  parameter int DATA_W     = crypto_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              zeroize,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] key,
  input  logic [DATA_W-1:0] data_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              done
);
  import crypto_pkg::*;

  // Counter value on the last round step; round_cnt is 8 bits wide.
  localparam logic [7:0]        LAST_RND = 8'(NUM_ROUNDS - 1);
  localparam logic [DATA_W-1:0] ONE      = {{(DATA_W-1){1'b0}}, 1'b1};

  dec_state_e        state_q;
  logic [DATA_W-1:0] r_data_q;
  logic [DATA_W-1:0] r_key_q;
  logic [7:0]        round_cnt_q;
  logic              in_ready_q;
  logic              out_valid_q;

  // FSM and datapath; zeroize overrides any handshake in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      r_data_q    <= '0;
      r_key_q     <= '0;
      round_cnt_q <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else if (zeroize) begin
      state_q     <= IDLE;
      r_data_q    <= '0;
      r_key_q     <= '0;
      round_cnt_q <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            r_data_q    <= data_in;
            r_key_q     <= key;
            round_cnt_q <= '0;
            in_ready_q  <= 1'b0;
            state_q     <= ROUND;
          end
        end
        ROUND: begin
          // Undo one mock round: subtract 1 modulo 2^DATA_W.
          r_data_q    <= r_data_q - ONE;
          round_cnt_q <= round_cnt_q + 8'd1;
          if (round_cnt_q == LAST_RND) begin
            state_q <= FINAL;
          end
        end
        FINAL: begin
          r_data_q    <= r_data_q ^ r_key_q;
          out_valid_q <= 1'b1;
          state_q     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            r_data_q    <= '0;
            r_key_q     <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  // r_data_q only holds plaintext in OUT; it is zero in IDLE after a block.
  assign data_out  = r_data_q;
  // Output handshake pulse, suppressed when zeroize wins the cycle.
  assign done      = out_valid_q & out_ready & ~zeroize;

endmodule

// File: tb/tb_crypto_decrypt_block.sv
// Directed bench for crypto_decrypt_block: unit 0 has NUM_ROUNDS=1, unit 1 has NUM_ROUNDS=4.
module tb_crypto_decrypt_block;
  import crypto_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset_n;
  logic               zeroize;
  logic [1:0]         in_valid;
  logic [1:0]         out_ready;
  logic [127:0]       key     [2];
  logic [127:0]       data_in [2];
  wire  [1:0]         in_ready;
  wire  [1:0]         out_valid;
  wire  [1:0]         done;
  wire  [127:0]       data_out [2];

  int n_chk = 0;
  int n_err = 0;

  localparam logic [127:0] KAT_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KAT_CT  = 128'h00102030405060708090a0b0c0d0e0f1;
  localparam logic [127:0] KAT_PT  = 128'h00112233445566778899aabbccddeeff;

  crypto_decrypt_block #(.NUM_ROUNDS(1)) u_dec0 (
    .clk(clk), .reset_n(reset_n), .zeroize(zeroize),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .key(key[0]), .data_in(data_in[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .data_out(data_out[0]), .done(done[0])
  );

  crypto_decrypt_block #(.NUM_ROUNDS(4)) u_dec1 (
    .clk(clk), .reset_n(reset_n), .zeroize(zeroize),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .key(key[1]), .data_in(data_in[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .data_out(data_out[1]), .done(done[1])
  );

  task automatic chkw(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Push one block through unit u, stalling the output for 'hold' cycles.
  task automatic run_block(input int u, input logic [127:0] d, input logic [127:0] k,
                           input int hold, output logic [127:0] res, output int lat);
    @(negedge clk);
    chk1("in_ready_idle", in_ready[u], 1'b1);
    in_valid[u]  = 1'b1;
    data_in[u]   = d;
    key[u]       = k;
    out_ready[u] = (hold == 0);
    @(negedge clk);
    in_valid[u] = 1'b0;
    data_in[u]  = ~d;
    key[u]      = ~k;
    chk1("in_ready_busy", in_ready[u], 1'b0);
    lat = 0;
    while (!out_valid[u] && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    res = data_out[u];
    if (!out_valid[u]) begin
      chk1("out_valid_timeout", out_valid[u], 1'b1);
      return;
    end
    for (int i = 0; i < hold; i++) begin
      chk1("bp_done", done[u], 1'b0);
      chk1("bp_in_ready", in_ready[u], 1'b0);
      chk1("bp_out_valid", out_valid[u], 1'b1);
      chkw("bp_data_stable", data_out[u], res);
      @(negedge clk);
    end
    out_ready[u] = 1'b1;
    #1;
    chk1("done_pulse", done[u], 1'b1);
    @(negedge clk);
    chk1("done_single", done[u], 1'b0);
    chk1("out_valid_drop", out_valid[u], 1'b0);
    chk1("in_ready_back", in_ready[u], 1'b1);
  endtask

  initial begin
    logic [127:0] res;
    logic [127:0] pt;
    logic [127:0] k;
    logic [127:0] ct;
    int           lat;
    int           guard;

    reset_n   = 1'b0;
    zeroize   = 1'b0;
    in_valid  = 2'b00;
    out_ready = 2'b00;
    for (int i = 0; i < 2; i++) begin
      key[i]     = '0;
      data_in[i] = '0;
    end
    #12;
    for (int i = 0; i < 2; i++) begin
      chk1("rst_in_ready", in_ready[i], 1'b1);
      chk1("rst_out_valid", out_valid[i], 1'b0);
      chk1("rst_done", done[i], 1'b0);
      chkw("rst_data_out", data_out[i], 128'h0);
    end
    chkw("rst_key0", u_dec0.r_key_q, 128'h0);
    chkw("rst_cnt0", 128'(u_dec0.round_cnt_q), 128'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Known answer and latency, NUM_ROUNDS=1
    run_block(0, KAT_CT, KAT_KEY, 0, res, lat);
    chkw("kat_data", res, KAT_PT);
    chkw("kat_latency", 128'(lat), 128'd2);
    chkw("kat_key_cleared", u_dec0.r_key_q, 128'h0);

    // Wrap 0 - 1
    run_block(0, 128'h0, 128'h0, 0, res, lat);
    chkw("wrap_data", res, {128{1'b1}});

    // Backpressure for 5 cycles
    run_block(0, KAT_CT, KAT_KEY, 5, res, lat);
    chkw("bp_data", res, KAT_PT);

    // Multi-round, NUM_ROUNDS=4
    run_block(1, 128'h10, 128'h0, 0, res, lat);
    chkw("mr_data", res, 128'hc);
    chkw("mr_latency", 128'(lat), 128'd5);

    // Loopback with the mock encryptor: ct = (pt ^ key) + 4
    for (int n = 0; n < 100; n++) begin
      pt = {$urandom(), $urandom(), $urandom(), $urandom()};
      k  = {$urandom(), $urandom(), $urandom(), $urandom()};
      ct = (pt ^ k) + 128'd4;
      run_block(1, ct, k, n % 3, res, lat);
      chkw("loopback", res, pt);
    end

    // Zeroize during ROUND
    @(negedge clk);
    in_valid[1] = 1'b1;
    data_in[1]  = KAT_CT;
    key[1]      = KAT_KEY;
    out_ready[1] = 1'b1;
    @(negedge clk);
    in_valid[1] = 1'b0;
    chkw("zr_in_round", 128'(u_dec1.state_q), 128'(ROUND));
    zeroize = 1'b1;
    #1;
    chk1("zr_no_done", done[1], 1'b0);
    @(negedge clk);
    zeroize = 1'b0;
    chk1("zr_in_ready", in_ready[1], 1'b1);
    chk1("zr_out_valid", out_valid[1], 1'b0);
    chkw("zr_key", u_dec1.r_key_q, 128'h0);
    chkw("zr_cnt", 128'(u_dec1.round_cnt_q), 128'h0);
    chkw("zr_state", 128'(u_dec1.state_q), 128'(IDLE));
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk1("zr_no_late_valid", out_valid[1], 1'b0);
    end

    // Zeroize in OUT together with out_ready
    @(negedge clk);
    in_valid[0]  = 1'b1;
    data_in[0]   = KAT_CT;
    key[0]       = KAT_KEY;
    out_ready[0] = 1'b0;
    @(negedge clk);
    in_valid[0] = 1'b0;
    guard = 0;
    while (!out_valid[0] && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    chk1("zo_reached_out", out_valid[0], 1'b1);
    zeroize      = 1'b1;
    out_ready[0] = 1'b1;
    #1;
    chk1("zo_no_done", done[0], 1'b0);
    @(negedge clk);
    zeroize      = 1'b0;
    out_ready[0] = 1'b0;
    chk1("zo_out_valid", out_valid[0], 1'b0);
    chk1("zo_in_ready", in_ready[0], 1'b1);
    chkw("zo_key", u_dec0.r_key_q, 128'h0);
    chkw("zo_data_out", data_out[0], 128'h0);
    run_block(0, KAT_CT, KAT_KEY, 0, res, lat);
    chkw("zo_after_data", res, KAT_PT);

    // Asynchronous reset while in FINAL
    @(negedge clk);
    in_valid[1]  = 1'b1;
    data_in[1]   = 128'h10;
    key[1]       = 128'h0;
    out_ready[1] = 1'b1;
    @(negedge clk);
    in_valid[1] = 1'b0;
    guard = 0;
    while (u_dec1.state_q !== FINAL && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    chkw("rf_in_final", 128'(u_dec1.state_q), 128'(FINAL));
    reset_n = 1'b0;
    #1;
    chk1("rf_in_ready", in_ready[1], 1'b1);
    chk1("rf_out_valid", out_valid[1], 1'b0);
    chk1("rf_done", done[1], 1'b0);
    chkw("rf_data_out", data_out[1], 128'h0);
    chkw("rf_key", u_dec1.r_key_q, 128'h0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk1("rf_post_in_ready", in_ready[1], 1'b1);
      chk1("rf_post_out_valid", out_valid[1], 1'b0);
    end
    run_block(1, 128'h10, 128'h0, 0, res, lat);
    chkw("rf_after_data", res, 128'hc);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
